// File: rtl/cfg_resp_pkg.sv
// -----------------------------------------------------------------------------
// cfg_resp_pkg
// Shared definitions for the config-space response queue: the handshake
// state encoding and the ack-protocol selector values.
// -----------------------------------------------------------------------------
package cfg_resp_pkg;

  // Handshake state machine encoding.
  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    WAIT_ACK_1 = 2'b01,
    WAIT_ACK_0 = 2'b10,
    ERROR      = 2'b11
  } hs_state_e;

  // ACK_MODE values.
  localparam int ACK_LEVEL = 0;  // four-phase: ack held until valid drops
  localparam int ACK_PULSE = 1;  // ack is a single-cycle strobe

endpackage

// File: rtl/cfg_resp_handshake.sv
// -----------------------------------------------------------------------------
// cfg_resp_handshake
// Valid/ack handshake toward TLX. Offers the queue head when the queue is
// non-empty, pops it on the edge that samples ack, and flags ack-protocol
// violations.
//
// Ports:
//   clock, reset   clock / asynchronous active-high reset
//   not_empty      queue holds at least one record
//   out_ack        ack from TLX
//   out_valid      registered valid toward TLX
//   pop            combinational strobe: head consumed on this edge
//   protocol_err   sticky ack-protocol violation
// -----------------------------------------------------------------------------
module cfg_resp_handshake
  import cfg_resp_pkg::*;
#(
  parameter int ACK_MODE = ACK_LEVEL
) (
  input  logic clock,
  input  logic reset,
  input  logic not_empty,
  input  logic out_ack,
  output logic out_valid,
  output logic pop,
  output logic protocol_err
);

  localparam bit IS_PULSE = (ACK_MODE == ACK_PULSE);

  hs_state_e state_q, state_d;
  logic      out_valid_q, out_valid_d;
  logic      perr_q, perr_d;
  logic      ack_q, ack_d;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    perr_d      = perr_q;
    ack_d       = out_ack;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        // Nothing is on offer, so any ack here is spurious.
        if (out_ack) perr_d = 1'b1;
        if (not_empty) begin
          state_d     = WAIT_ACK_1;
          out_valid_d = 1'b1;
        end
      end
      WAIT_ACK_1: begin
        if (out_ack) begin
          pop         = 1'b1;
          out_valid_d = 1'b0;
          state_d     = IS_PULSE ? IDLE : WAIT_ACK_0;
        end
      end
      WAIT_ACK_0: begin
        // Unreachable in pulse mode; treat as a corrupted encoding there.
        if (IS_PULSE) begin
          state_d     = ERROR;
          out_valid_d = 1'b0;
        end else if (!out_ack) begin
          state_d = IDLE;
        end
      end
      ERROR: begin
        out_valid_d = 1'b0;
      end
      default: begin
        state_d     = ERROR;
        out_valid_d = 1'b0;
      end
    endcase

    // A strobe must not span two consecutive edges.
    if (IS_PULSE && out_ack && ack_q) perr_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      perr_q      <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      perr_q      <= perr_d;
      ack_q       <= ack_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign protocol_err = perr_q;

endmodule

// File: rtl/cfg_resp_queue.sv
// -----------------------------------------------------------------------------
// cfg_resp_queue
// In-order response queue between the config-space responder and the TLX
// response port. Stores DEPTH records of WIDTH bits and hands them to TLX
// over a valid/ack handshake (four-phase or pulse ack).
//
// Ports:
//   clock, reset        clock / asynchronous active-high reset
//   in_data, in_valid   record to enqueue
//   buffers_available   DEPTH minus occupancy
//   out_data            head record, zero when the queue is empty
//   out_valid, out_ack  handshake toward TLX
//   fifo_overflow       enqueue attempted while full (this cycle)
//   overflow_err        sticky overflow flag
//   protocol_err        sticky ack-protocol violation
// -----------------------------------------------------------------------------
module cfg_resp_queue
  import cfg_resp_pkg::*;
#(
  parameter int WIDTH    = 68,
  parameter int DEPTH    = 8,
  parameter int ACK_MODE = ACK_LEVEL,
  parameter int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [CNT_W-1:0] buffers_available,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ack,
  output logic             fifo_overflow,
  output logic             overflow_err,
  output logic             protocol_err
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrptr_q, wrptr_d;
  logic [PTR_W-1:0] rdptr_q, rdptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_err_q, ovf_err_d;
  logic             full, push, pop, not_empty;

  // Fullness uses the pre-pop count: a write on a full queue is dropped
  // even if the head is popped on the same edge.
  assign full              = (count_q == DEPTH_C);
  assign not_empty         = (count_q != '0);
  assign push              = in_valid && !full;
  assign fifo_overflow     = in_valid && full;
  assign buffers_available = DEPTH_C - count_q;
  assign out_data          = not_empty ? mem_q[rdptr_q] : '0;
  assign overflow_err      = ovf_err_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wrptr_d   = wrptr_q;
    rdptr_d   = rdptr_q;
    ovf_err_d = ovf_err_q | fifo_overflow;
    if (push) wrptr_d = wrptr_q + PTR_W'(1);
    if (pop)  rdptr_d = rdptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrptr_q   <= '0;
      rdptr_q   <= '0;
      count_q   <= '0;
      ovf_err_q <= 1'b0;
    end else begin
      wrptr_q   <= wrptr_d;
      rdptr_q   <= rdptr_d;
      count_q   <= count_d;
      ovf_err_q <= ovf_err_d;
    end
  end

  // NOTE: the storage array has no reset; empty slots are never observed
  // because out_data is forced to zero while the count is zero.
  always_ff @(posedge clock) begin
    if (push) mem_q[wrptr_q] <= in_data;
  end

  cfg_resp_handshake #(
    .ACK_MODE (ACK_MODE)
  ) u_handshake (
    .clock        (clock),
    .reset        (reset),
    .not_empty    (not_empty),
    .out_ack      (out_ack),
    .out_valid    (out_valid),
    .pop          (pop),
    .protocol_err (protocol_err)
  );

endmodule
